// File: rtl/cpu_sequencer_if.sv
// Datapath-side bus of the run sequencer: control_unit write requests and
// memory readiness flow into the sequencer, gated write strobes flow out.
interface cpu_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] pc;
    logic              dest_a_req;
    logic              dest_d_req;
    logic              dest_m_req;
    logic              set_pc_req;
    logic              mem_ready;
    logic              ir_load;
    logic              reg_a_en;
    logic              reg_d_en;
    logic              reg_m_en;
    logic              pc_write;
    logic              pc_inc;

    // Datapath / control side: produces requests, consumes strobes
    modport master (
        output pc, dest_a_req, dest_d_req, dest_m_req, set_pc_req, mem_ready,
        input  ir_load, reg_a_en, reg_d_en, reg_m_en, pc_write, pc_inc
    );

    // Sequencer side: consumes requests, produces strobes
    modport slave (
        input  pc, dest_a_req, dest_d_req, dest_m_req, set_pc_req, mem_ready,
        output ir_load, reg_a_en, reg_d_en, reg_m_en, pc_write, pc_inc
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle run controller for the 16-bit A/D/M accumulator CPU.
// Steps each instruction through FETCH, EXECUTE and WRITEBACK, turning the
// control unit's write requests into one-cycle strobes, and provides
// run/halt/single-step control, a PC breakpoint and activity counters.
module cpu_sequencer #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              step,
    input  logic              halt,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    cpu_sequencer_if.slave    bus,
    output logic [1:0]        state,
    output logic              halted,
    output logic              bp_hit,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [1:0] {
        S_HALT      = 2'd0,
        S_FETCH     = 2'd1,
        S_EXECUTE   = 2'd2,
        S_WRITEBACK = 2'd3
    } seq_state_t;

    seq_state_t cur_state;
    logic       run_mode;
    logic       halt_pending;
    logic       bp_skip;
    logic       bp_match;
    logic       wb_done;

    assign state  = cur_state;
    assign halted = (cur_state == S_HALT);

    // Breakpoint match (suppressed for the first fetch after leaving HALT) and WRITEBACK completion
    always_comb begin
        bp_match = bp_en && (bus.pc == bp_addr) && !bp_skip;
        wb_done  = (cur_state == S_WRITEBACK) && (!bus.dest_m_req || bus.mem_ready);
    end

    // Strobes are pure decodes of state and requests so a reset drops them immediately
    always_comb begin
        bus.ir_load  = (cur_state == S_FETCH) && !bp_match;
        bus.reg_a_en = wb_done && bus.dest_a_req;
        bus.reg_d_en = wb_done && bus.dest_d_req;
        bus.reg_m_en = wb_done && bus.dest_m_req;
        bus.pc_write = wb_done && bus.set_pc_req;
        bus.pc_inc   = wb_done && !bus.set_pc_req;
    end

    // Instruction schedule plus debug control; a halt request only takes effect at retirement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state    <= S_HALT;
            run_mode     <= 1'b0;
            halt_pending <= 1'b0;
            bp_skip      <= 1'b0;
            bp_hit       <= 1'b0;
        end else begin
            case (cur_state)
                S_HALT: begin
                    if (run || step) begin
                        cur_state    <= S_FETCH;
                        run_mode     <= run;
                        bp_hit       <= 1'b0;
                        halt_pending <= 1'b0;
                        bp_skip      <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (halt) begin
                        halt_pending <= 1'b1;
                    end
                    if (bp_match) begin
                        cur_state <= S_HALT;
                        bp_hit    <= 1'b1;
                    end else begin
                        cur_state <= S_EXECUTE;
                        bp_skip   <= 1'b0;
                    end
                end
                S_EXECUTE: begin
                    if (halt) begin
                        halt_pending <= 1'b1;
                    end
                    cur_state <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    if (halt) begin
                        halt_pending <= 1'b1;
                    end
                    if (wb_done) begin
                        if (halt_pending || halt || !run_mode) begin
                            cur_state <= S_HALT;
                        end else begin
                            cur_state <= S_FETCH;
                        end
                    end
                end
                default: cur_state <= S_HALT;
            endcase
        end
    end

    // Free-running wrap-around counters of busy cycles and retired instructions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (cur_state != S_HALT) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
            if (wb_done) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

endmodule
